csr_master_arbiter: RTL and testbench
=====================================

CSR_MASTER_ARBITER -- requirements
Module: csr_master_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width of all ports.
REQ-002 Parameter DATA_W, default 32, data width; byteenable width is DATA_W/8.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024, slave-stall cycles before a transaction is aborted.
REQ-004 clk_clk  in  1  single clock; all logic rising-edge.
REQ-005 clk_reset_reset_n  in  1  asynchronous, active-low reset.
REQ-006 m0_address/m0_read/m0_write/m0_writedata/m0_byteenable  in  ADDR_W/1/1/DATA_W/DATA_W/8  requester 0 (JTAG CSR master) command.
REQ-007 m0_readdata  out  DATA_W, m0_readdatavalid  out  1, m0_waitrequest  out  1  requester 0 response.
REQ-008 m1_* ports identical to m0_*, for requester 1 (local host).
REQ-009 s_address/s_read/s_write/s_writedata/s_byteenable  out  same widths as m0  shared CSR slave command.
REQ-010 s_readdata  in  DATA_W, s_readdatavalid  in  1, s_waitrequest  in  1  shared slave response.
REQ-011 err_timeout  out  1  sticky timeout flag; err_clear  in  1  synchronous clear.

Function
REQ-012 The block SHALL use FSM states IDLE, CMD, RDWAIT, ABORT; at most one transaction is outstanding.
REQ-013 In IDLE, a requester is active when its read or write is high; the arbiter SHALL select one and move to CMD on the next edge.
REQ-014 Selection SHALL be round-robin over 2 requesters; on simultaneous requests, the requester not granted last wins; after reset, m0 wins.
REQ-015 In CMD, the s_* command outputs SHALL equal the granted requester's inputs combinationally; in all other states, s_read and s_write SHALL be 0.
REQ-016 The granted requester's waitrequest SHALL equal s_waitrequest in CMD; every other waitrequest, and all waitrequests in IDLE/RDWAIT/ABORT, SHALL be 1.
REQ-017 In CMD with s_waitrequest=0: a write SHALL return to IDLE; a read SHALL go to RDWAIT.
REQ-018 If read and write are both high on the granted requester, the block SHALL perform the write only.
REQ-019 In RDWAIT, on s_readdatavalid=1 the block SHALL drive the granted requester's readdatavalid=1 with readdata=s_readdata in the same cycle, then return to IDLE.
REQ-020 s_readdatavalid outside RDWAIT SHALL be ignored.
REQ-021 Non-granted readdatavalid SHALL be 0.
REQ-022 Minimum latency SHALL be 1 cycle from request to s_* command; read data passes with 0 added cycles.
REQ-023 A stall counter SHALL clear on entry to CMD and increment each cycle in CMD or RDWAIT.
REQ-024 When the stall counter reaches TIMEOUT_CYCLES-1 without completion, the block SHALL enter ABORT on the next edge and set err_timeout.
REQ-025 ABORT SHALL last one cycle, then return to IDLE.
REQ-026 In ABORT, the granted requester's waitrequest SHALL be 0 if aborted from CMD.
REQ-027 In ABORT, a read SHALL additionally receive readdatavalid=1 with readdata=32'hDEADBEEF.
REQ-028 err_timeout SHALL remain set until err_clear=1; if a set and a clear occur in the same cycle, set wins.
REQ-029 The last-grant pointer SHALL update on leaving CMD or RDWAIT toward IDLE or ABORT.

Reset
REQ-030 While reset is asserted, the block SHALL hold: state=IDLE, last-grant=m1 (so m0 has priority), stall counter=0, err_timeout=0.
REQ-031 While reset is asserted, outputs SHALL be: all s_read/s_write=0, all waitrequest=1, all readdatavalid=0, all readdata=0.
REQ-032 Reset asserted mid-transaction SHALL abandon the transaction with no response; a late s_readdatavalid is discarded per REQ-020.

Structure
REQ-033 Package csr_arb_pkg SHALL hold the state enum, the TIMEOUT_DATA constant (32'hDEADBEEF) and the default parameter values.
REQ-034 Round-robin selection SHALL be a sub-module csr_arb_rr2 (inputs: req[1:0], last; output: grant one-hot); the FSM, counter and muxes stay in the top.

Verification
REQ-035 m0 write addr 0x10 data 0x55, s_waitrequest low -> s_write one cycle after request, m0_waitrequest low in that cycle, FSM back in IDLE.
REQ-036 m0 and m1 read simultaneously, slave returns 0xA then 0xB -> m0 is served first with 0xA, m1 second with 0xB; m1_waitrequest=1 throughout m0's transaction.
REQ-037 Back-to-back requests from both requesters for 4 transactions -> grants alternate m0, m1, m0, m1.
REQ-038 m1 read, s_readdatavalid never asserted, TIMEOUT_CYCLES=16 -> ABORT delivers m1_readdatavalid with 0xDEADBEEF; err_timeout=1 until err_clear.
REQ-039 Reset asserted during RDWAIT, then a stray s_readdatavalid -> no readdatavalid on either requester; all outputs at reset values.

Source files
------------

// File: rtl/csr_arb_pkg.sv
// Shared types and constants for the two-requester CSR arbiter.
//   arb_state_e      : arbiter FSM states
//   TIMEOUT_DATA     : read data returned to a requester whose read was aborted
//   Def*             : default parameter values for csr_master_arbiter
package csr_arb_pkg;

    localparam int unsigned DefAddrW         = 32;
    localparam int unsigned DefDataW         = 32;
    localparam int unsigned DefTimeoutCycles = 1024;

    localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        StIdle,
        StCmd,
        StRdWait,
        StAbort
    } arb_state_e;

endpackage

// File: rtl/csr_arb_rr2.sv
// Two-way round-robin selector.
//   req   : request vector, bit i = requester i active
//   last  : index of the requester granted most recently
//   grant : one-hot grant (all zero when nothing is requested)
module csr_arb_rr2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = req;
        // On contention the requester that was not served last wins.
        if (req == 2'b11) begin
            grant = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/csr_master_arbiter.sv
// Arbitrates two Avalon-MM style CSR requesters (m0: JTAG master, m1: local host)
// onto one shared CSR slave, one transaction at a time, with a stall timeout.
//   clk_clk, clk_reset_reset_n : clock, asynchronous active-low reset
//   m0_* / m1_*                : requester command in, readdata/readdatavalid/waitrequest out
//   s_*                        : shared slave command out, response in
//   err_timeout / err_clear    : sticky timeout flag, synchronous clear
module csr_master_arbiter
    import csr_arb_pkg::*;
#(
    parameter int unsigned ADDR_W         = DefAddrW,
    parameter int unsigned DATA_W         = DefDataW,
    parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
    input  logic                clk_clk,
    input  logic                clk_reset_reset_n,

    input  logic [ADDR_W-1:0]   m0_address,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    output logic                m0_waitrequest,

    input  logic [ADDR_W-1:0]   m1_address,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
    output logic                m1_waitrequest,

    output logic [ADDR_W-1:0]   s_address,
    output logic                s_read,
    output logic                s_write,
    output logic [DATA_W-1:0]   s_writedata,
    output logic [DATA_W/8-1:0] s_byteenable,
    input  logic [DATA_W-1:0]   s_readdata,
    input  logic                s_readdatavalid,
    input  logic                s_waitrequest,

    output logic                err_timeout,
    input  logic                err_clear
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    arb_state_e      state_q, state_d;
    logic            gnt_q, gnt_d;        // granted requester index
    logic            last_q, last_d;      // last-served requester index
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            from_cmd_q, from_cmd_d;  // abort was taken from the command phase
    logic            op_rd_q, op_rd_d;        // transaction in flight is a read

    logic [1:0]          req, grant;
    logic [ADDR_W-1:0]   sel_address;
    logic                sel_read, sel_write, sel_rd_only, timeout_hit;
    logic [DATA_W-1:0]   sel_writedata;
    logic [DATA_W/8-1:0] sel_byteenable;
    logic                wait_gnt, rdv_gnt;
    logic [DATA_W-1:0]   rdata_gnt;

    assign req = {m1_read | m1_write, m0_read | m0_write};

    csr_arb_rr2 u_rr2 (
        .req   (req),
        .last  (last_q),
        .grant (grant)
    );

    assign sel_address    = gnt_q ? m1_address    : m0_address;
    assign sel_read       = gnt_q ? m1_read       : m0_read;
    assign sel_write      = gnt_q ? m1_write      : m0_write;
    assign sel_writedata  = gnt_q ? m1_writedata  : m0_writedata;
    assign sel_byteenable = gnt_q ? m1_byteenable : m0_byteenable;
    // Read and write together is treated as a write.
    assign sel_rd_only    = sel_read & ~sel_write;
    assign timeout_hit    = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_clk or negedge clk_reset_reset_n) begin
        if (!clk_reset_reset_n) begin
            state_q    <= StIdle;
            gnt_q      <= 1'b0;
            last_q     <= 1'b1;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            from_cmd_q <= 1'b0;
            op_rd_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            from_cmd_q <= from_cmd_d;
            op_rd_q    <= op_rd_d;
        end
    end

    // Next-state logic. A timeout set in the same cycle as err_clear wins.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        err_d      = err_q & ~err_clear;
        from_cmd_d = from_cmd_q;
        op_rd_d    = op_rd_q;
        unique case (state_q)
            StIdle: begin
                if (|grant) begin
                    state_d = StCmd;
                    gnt_d   = grant[1];
                    cnt_d   = '0;
                end
            end
            StCmd: begin
                cnt_d   = cnt_q + CntW'(1);
                op_rd_d = sel_rd_only;
                if (!s_waitrequest) begin
                    if (sel_rd_only) begin
                        state_d = StRdWait;
                    end else begin
                        state_d = StIdle;
                        last_d  = gnt_q;
                    end
                end else if (timeout_hit) begin
                    state_d    = StAbort;
                    from_cmd_d = 1'b1;
                    err_d      = 1'b1;
                    last_d     = gnt_q;
                end
            end
            StRdWait: begin
                cnt_d = cnt_q + CntW'(1);
                if (s_readdatavalid) begin
                    state_d = StIdle;
                    last_d  = gnt_q;
                end else if (timeout_hit) begin
                    state_d    = StAbort;
                    from_cmd_d = 1'b0;
                    err_d      = 1'b1;
                    last_d     = gnt_q;
                end
            end
            StAbort: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Slave command and granted-requester response; idle values elsewhere.
    always_comb begin
        s_address    = '0;
        s_read       = 1'b0;
        s_write      = 1'b0;
        s_writedata  = '0;
        s_byteenable = '0;
        wait_gnt     = 1'b1;
        rdv_gnt      = 1'b0;
        rdata_gnt    = '0;
        unique case (state_q)
            StCmd: begin
                s_address    = sel_address;
                s_read       = sel_rd_only;
                s_write      = sel_write;
                s_writedata  = sel_writedata;
                s_byteenable = sel_byteenable;
                wait_gnt     = s_waitrequest;
            end
            StRdWait: begin
                if (s_readdatavalid) begin
                    rdv_gnt   = 1'b1;
                    rdata_gnt = s_readdata;
                end
            end
            StAbort: begin
                wait_gnt = ~from_cmd_q;
                if (op_rd_q) begin
                    rdv_gnt   = 1'b1;
                    rdata_gnt = DATA_W'(TIMEOUT_DATA);
                end
            end
            default: ;
        endcase
    end

    assign m0_waitrequest   = gnt_q ? 1'b1 : wait_gnt;
    assign m1_waitrequest   = gnt_q ? wait_gnt : 1'b1;
    assign m0_readdatavalid = ~gnt_q & rdv_gnt;
    assign m1_readdatavalid = gnt_q & rdv_gnt;
    assign m0_readdata      = gnt_q ? '0 : rdata_gnt;
    assign m1_readdata      = gnt_q ? rdata_gnt : '0;
    assign err_timeout      = err_q;

endmodule

// File: tb/tb_csr_master_arbiter.sv
module tb_csr_master_arbiter;

    logic        clk;
    logic        rst_n;
    logic [31:0] m0_address, m1_address, s_address;
    logic        m0_read, m0_write, m1_read, m1_write, s_read, s_write;
    logic [31:0] m0_writedata, m1_writedata, s_writedata;
    logic [3:0]  m0_byteenable, m1_byteenable, s_byteenable;
    logic [31:0] m0_readdata, m1_readdata, s_readdata;
    logic        m0_readdatavalid, m1_readdatavalid, s_readdatavalid;
    logic        m0_waitrequest, m1_waitrequest, s_waitrequest;
    logic        err_timeout, err_clear;

    int total = 0;
    int bad   = 0;
    int abort_cyc;
    logic nxt_m1;

    typedef struct packed {
        logic        which;
        logic [31:0] data;
    } rsp_t;
    rsp_t sb[$];

    csr_master_arbiter #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_clk           (clk),
        .clk_reset_reset_n (rst_n),
        .m0_address        (m0_address),
        .m0_read           (m0_read),
        .m0_write          (m0_write),
        .m0_writedata      (m0_writedata),
        .m0_byteenable     (m0_byteenable),
        .m0_readdata       (m0_readdata),
        .m0_readdatavalid  (m0_readdatavalid),
        .m0_waitrequest    (m0_waitrequest),
        .m1_address        (m1_address),
        .m1_read           (m1_read),
        .m1_write          (m1_write),
        .m1_writedata      (m1_writedata),
        .m1_byteenable     (m1_byteenable),
        .m1_readdata       (m1_readdata),
        .m1_readdatavalid  (m1_readdatavalid),
        .m1_waitrequest    (m1_waitrequest),
        .s_address         (s_address),
        .s_read            (s_read),
        .s_write           (s_write),
        .s_writedata       (s_writedata),
        .s_byteenable      (s_byteenable),
        .s_readdata        (s_readdata),
        .s_readdatavalid   (s_readdatavalid),
        .s_waitrequest     (s_waitrequest),
        .err_timeout       (err_timeout),
        .err_clear         (err_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        m0_address = '0; m0_read = 0; m0_write = 0; m0_writedata = '0; m0_byteenable = '0;
        m1_address = '0; m1_read = 0; m1_write = 0; m1_writedata = '0; m1_byteenable = '0;
        s_readdata = '0; s_readdatavalid = 0; s_waitrequest = 0; err_clear = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_rw"}, {s_read, s_write}, 2'b00);
        check({tag, "_wait"}, {m0_waitrequest, m1_waitrequest}, 2'b11);
        check({tag, "_rdv"}, {m0_readdatavalid, m1_readdatavalid}, 2'b00);
        check({tag, "_rdata"}, {m0_readdata, m1_readdata}, 64'h0);
        check({tag, "_err"}, err_timeout, 1'b0);
    endtask

    // Scoreboard consumer: every readdatavalid must match the oldest expected response.
    always @(negedge clk) begin
        if (m0_readdatavalid || m1_readdatavalid) begin
            if (sb.size() == 0) begin
                check("rdv_unexpected", {m1_readdatavalid, m0_readdatavalid}, 2'b00);
            end else begin
                rsp_t e;
                e = sb.pop_front();
                check("rsp_port", {m1_readdatavalid, m0_readdatavalid}, e.which ? 2'b10 : 2'b01);
                check("rsp_data", e.which ? m1_readdata : m0_readdata, e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        // Reset values, with live inputs that must not leak through.
        rst_n = 1'b0;
        idle_inputs();
        m0_read = 1; m1_write = 1; s_readdatavalid = 1; s_readdata = 32'h1234;
        smp();
        check_reset_outputs("reset");

        // Simultaneous reads: m0 first (reset priority), m1 held off meanwhile.
        do_reset();
        m0_read = 1; m0_address = 32'h20; m1_read = 1; m1_address = 32'h24;
        smp();
        check("rr_idle_wait", {m0_waitrequest, m1_waitrequest, s_read}, 3'b110);
        tick(); smp();
        check("rr_m0_cmd_addr", s_address, 32'h20);
        check("rr_m0_cmd", {s_read, m0_waitrequest, m1_waitrequest}, 3'b101);
        tick(); m0_read = 0; sb.push_back('{which: 1'b0, data: 32'hA}); smp();
        check("rr_m0_rdwait", {s_read, m1_waitrequest}, 2'b01);
        tick(); s_readdatavalid = 1; s_readdata = 32'hA; smp();
        check("rr_m1_held", m1_waitrequest, 1'b1);
        tick(); s_readdatavalid = 0; smp();
        check("rr_back_idle", {s_read, m1_waitrequest}, 2'b01);
        tick(); smp();
        check("rr_m1_cmd_addr", s_address, 32'h24);
        check("rr_m1_cmd", {s_read, m0_waitrequest, m1_waitrequest}, 3'b110);
        tick(); m1_read = 0; sb.push_back('{which: 1'b1, data: 32'hB});
        s_readdatavalid = 1; s_readdata = 32'hB; smp();
        tick(); s_readdatavalid = 0; smp();
        check("rr_sb_drained", sb.size(), 0);

        // Single m0 write, then an m1 write right away proves the FSM is idle again.
        do_reset();
        m0_write = 1; m0_address = 32'h10; m0_writedata = 32'h55; m0_byteenable = 4'hF;
        smp();
        check("wr_idle_no_cmd", s_write, 1'b0);
        tick(); smp();
        check("wr_cmd", {s_write, m0_waitrequest}, 2'b10);
        check("wr_addr_data", {s_address, s_writedata}, {32'h10, 32'h55});
        check("wr_be", s_byteenable, 4'hF);
        tick(); m0_write = 0; m1_write = 1; m1_address = 32'h30; smp();
        check("wr_done_idle", {s_write, m0_waitrequest}, 2'b01);
        tick(); smp();
        check("wr_next_cmd", {s_write, s_address, m1_waitrequest}, {1'b1, 32'h30, 1'b0});
        tick(); m1_write = 0;

        // Back-to-back contention: grants alternate m0, m1, m0, m1.
        do_reset();
        m0_write = 1; m0_address = 32'h100; m1_write = 1; m1_address = 32'h200;
        nxt_m1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(); smp();
            check("b2b_cmd_addr", s_address, nxt_m1 ? 32'h200 : 32'h100);
            check("b2b_cmd_wait", {s_write, m0_waitrequest, m1_waitrequest},
                  nxt_m1 ? 3'b110 : 3'b101);
            tick(); smp();
            check("b2b_idle", s_write, 1'b0);
            nxt_m1 = ~nxt_m1;
        end
        m0_write = 0; m1_write = 0;

        // m1 read whose data never arrives: abort after 16 stalled cycles.
        do_reset();
        m1_read = 1; m1_address = 32'h40;
        sb.push_back('{which: 1'b1, data: 32'hDEADBEEF});
        abort_cyc = 0;
        for (int c = 1; c <= 40 && abort_cyc == 0; c++) begin
            tick();
            if (c == 2) m1_read = 0;
            smp();
            if (c == 16) check("to_err_before", err_timeout, 1'b0);
            if (m1_readdatavalid) abort_cyc = c;
        end
        check("to_abort_cycle", abort_cyc, 17);
        check("to_abort_wait", m1_waitrequest, 1'b1);
        check("to_err_set", err_timeout, 1'b1);
        tick(); smp();
        check("to_err_sticky", {err_timeout, s_read}, 2'b10);
        repeat (3) tick();
        smp();
        check("to_err_sticky2", err_timeout, 1'b1);
        tick(); err_clear = 1; smp();
        check("to_err_clear_sync", err_timeout, 1'b1);
        tick(); err_clear = 0; smp();
        check("to_err_cleared", err_timeout, 1'b0);

        // Write stalled in the command phase; clear held high so set must beat clear.
        s_waitrequest = 1; err_clear = 1;
        m0_write = 1; m0_address = 32'h50;
        abort_cyc = 0;
        for (int c = 1; c <= 40 && abort_cyc == 0; c++) begin
            tick(); smp();
            if (c == 16) check("cto_err_before", err_timeout, 1'b0);
            if (!m0_waitrequest) abort_cyc = c;
        end
        check("cto_abort_cycle", abort_cyc, 17);
        check("cto_abort_cmd", {s_write, m0_readdatavalid, m1_waitrequest}, 3'b001);
        check("cto_set_wins", err_timeout, 1'b1);
        tick(); m0_write = 0; smp();
        check("cto_clear_after", err_timeout, 1'b0);
        err_clear = 0; s_waitrequest = 0;

        // Reset during the read-wait phase, then a stray readdatavalid.
        do_reset();
        m0_read = 1; m0_address = 32'h60;
        tick();
        tick(); m0_read = 0;
        rst_n = 0; s_readdatavalid = 1; s_readdata = 32'h77; smp();
        check_reset_outputs("midrst");
        tick(); rst_n = 1; smp();
        check("stray_rdv", {m0_readdatavalid, m1_readdatavalid, m0_readdata}, 34'h0);
        tick(); s_readdatavalid = 0; smp();

        check("sb_empty_end", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
